// File: rtl/wb_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// wb_reg_bank_pkg
// Shared types, constants and helpers for the Wishbone control/status register
// bank.
//   - reg_bit_mode_t : access mode of a single register bit
//   - bit_width()    : bits needed to encode a value (minimum 1)
//   - reg_mask()     : flat one-hot mask used to build bank parameters
//   - CPU/VIDEO constants for the default two-register control block
// -----------------------------------------------------------------------------
package wb_reg_bank_pkg;

  typedef enum logic [1:0] {
    REG_BIT_RW,
    REG_BIT_RO,
    REG_BIT_W1C,
    REG_BIT_PULSE
  } reg_bit_mode_t;

  // Number of bits needed to hold 'value' (0 still needs one bit).
  function automatic int bit_width(input int value);
    int w;
    w = 1;
    while ((64'(1) << w) <= 64'(value)) w++;
    return w;
  endfunction

  // Geometry of the default CPU/VIDEO control block.
  localparam int REG_BANK_COUNT = 2;
  localparam int REG_DATA_WIDTH = 8;
  localparam int REG_FLAT_WIDTH = REG_BANK_COUNT * REG_DATA_WIDTH;
  localparam int REG_ADDR_WIDTH = bit_width(REG_BANK_COUNT - 1);

  // One-hot flat mask selecting bit 'bit_idx' of register 'reg_idx'.
  function automatic logic [REG_FLAT_WIDTH-1:0] reg_mask(input int reg_idx,
                                                         input int bit_idx);
    logic [REG_FLAT_WIDTH-1:0] m;
    m = '0;
    m[reg_idx*REG_DATA_WIDTH + bit_idx] = 1'b1;
    return m;
  endfunction

  // Classify one bit from its three mode-mask bits.
  function automatic reg_bit_mode_t bit_mode(input logic ro, input logic w1c,
                                             input logic pulse);
    if (ro)         return REG_BIT_RO;
    else if (w1c)   return REG_BIT_W1C;
    else if (pulse) return REG_BIT_PULSE;
    else            return REG_BIT_RW;
  endfunction

  // CPU/VIDEO register map.
  localparam int REG_CPU_IDX        = 0;
  localparam int REG_VIDEO_IDX      = 1;
  localparam int REG_CPU_READY_BIT  = 0;
  localparam int REG_CPU_RESET_BIT  = 1;  // CPU held in reset after power-up
  localparam int REG_VIDEO_MODE_BIT = 0;

  localparam logic [REG_FLAT_WIDTH-1:0] REG_BANK_RESET_VALUE =
    reg_mask(REG_CPU_IDX, REG_CPU_RESET_BIT);

endpackage

// File: rtl/wb_reg_bank_cell.sv
// -----------------------------------------------------------------------------
// wb_reg_bank_cell
// One DATA_WIDTH register with per-bit access modes.
// Ports:
//   clock_i, reset_n_i : clock, asynchronous active-low reset
//   wr_en_i            : write strobe for this register (accepted write)
//   wr_data_i          : write data
//   hw_event_i         : per-bit set pulses for W1C bits
//   hw_status_i        : live values for RO bits
//   rd_data_o          : value returned on a read (pre-write state)
//   reg_o              : output image (RW/W1C levels, PULSE pulses, RO live)
// -----------------------------------------------------------------------------
module wb_reg_bank_cell
  import wb_reg_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] W1C_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] PULSE_MASK  = '0
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [DATA_WIDTH-1:0] hw_event_i,
  input  logic [DATA_WIDTH-1:0] hw_status_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [DATA_WIDTH-1:0] reg_o
);

  localparam logic [DATA_WIDTH-1:0] RW_MASK   = ~(RO_MASK | W1C_MASK | PULSE_MASK);
  // RO bits are never stored and pulse bits always come up clear.
  localparam logic [DATA_WIDTH-1:0] RST_STORE = RESET_VALUE & ~RO_MASK & ~PULSE_MASK;

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] wr_ones;

  // Bits being written with 1 in this cycle (zero when not written).
  assign wr_ones = wr_en_i ? wr_data_i : '0;

  always_comb begin
    value_d = '0;
    value_d = (RW_MASK    & (wr_en_i ? wr_data_i : value_q))
            // Event is OR-ed after the clear so a simultaneous set wins.
            | (W1C_MASK   & ((value_q & ~wr_ones) | hw_event_i))
            // Pulse bits hold for exactly the cycle after the write.
            | (PULSE_MASK & wr_ones);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) value_q <= RST_STORE;
    else            value_q <= value_d;
  end

  assign rd_data_o = (RO_MASK & hw_status_i) | (~RO_MASK & ~PULSE_MASK & value_q);
  assign reg_o     = (RO_MASK & hw_status_i) | (~RO_MASK & value_q);

endmodule

// File: rtl/wb_reg_bank.sv
// -----------------------------------------------------------------------------
// wb_reg_bank
// Wishbone-pipelined slave register bank of REG_COUNT x DATA_WIDTH registers,
// each bit RW, RO (hardware status), W1C (sticky event) or PULSE.
// Ports:
//   clock_i, reset_n_i          : clock, asynchronous active-low reset
//   wb_addr_i, wb_data_i        : register index, write data
//   wb_we_i, wb_cycle_i,
//   wb_strobe_i                 : write enable, bus cycle, request valid
//   wb_data_o, wb_ack_o         : read data (0 outside ack), acknowledge
//   wb_stall_o                  : always 0
//   hw_status_i, hw_event_i     : RO live values, W1C set pulses (flat)
//   reg_o                       : flat register image
// -----------------------------------------------------------------------------
module wb_reg_bank
  import wb_reg_bank_pkg::*;
#(
  parameter int REG_COUNT  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = bit_width(REG_COUNT - 1),
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] RO_MASK     = '0,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] W1C_MASK    = '0,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] PULSE_MASK  = '0
) (
  input  logic                            clock_i,
  input  logic                            reset_n_i,
  input  logic [ADDR_WIDTH-1:0]           wb_addr_i,
  input  logic [DATA_WIDTH-1:0]           wb_data_i,
  output logic [DATA_WIDTH-1:0]           wb_data_o,
  input  logic                            wb_we_i,
  input  logic                            wb_cycle_i,
  input  logic                            wb_strobe_i,
  output logic                            wb_stall_o,
  output logic                            wb_ack_o,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] hw_status_i,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] hw_event_i,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_o
);

  // Elaboration-time parameter checks.
  if (REG_COUNT < 1) begin : g_bad_count
    $fatal(1, "wb_reg_bank: REG_COUNT must be >= 1");
  end
  if (((RO_MASK & W1C_MASK) | (RO_MASK & PULSE_MASK) | (W1C_MASK & PULSE_MASK)) != '0)
  begin : g_bad_masks
    $fatal(1, "wb_reg_bank: RO_MASK, W1C_MASK and PULSE_MASK overlap");
  end

  // Handshake: a request is accepted on every edge where wb_cycle_i and
  // wb_strobe_i are both 1 (stall is never raised). The write takes effect
  // at that edge and wb_ack_o is 1 for exactly the following cycle with the
  // read data, unless wb_cycle_i has dropped, which suppresses the ack.
  logic                  accept;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] cell_rd [REG_COUNT];
  logic [DATA_WIDTH-1:0] rd_sel;

  assign accept     = wb_cycle_i & wb_strobe_i;
  assign wb_stall_o = 1'b0;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_cell
    wb_reg_bank_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH]),
      .RO_MASK     (RO_MASK[i*DATA_WIDTH +: DATA_WIDTH]),
      .W1C_MASK    (W1C_MASK[i*DATA_WIDTH +: DATA_WIDTH]),
      .PULSE_MASK  (PULSE_MASK[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clock_i     (clock_i),
      .reset_n_i   (reset_n_i),
      .wr_en_i     (accept & wb_we_i & (32'(wb_addr_i) == i)),
      .wr_data_i   (wb_data_i),
      .hw_event_i  (hw_event_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .hw_status_i (hw_status_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_data_o   (cell_rd[i]),
      .reg_o       (reg_o[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Out-of-range indices match no cell and therefore read as 0.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (32'(wb_addr_i) == i) rd_sel = cell_rd[i];
    end
  end

  always_comb begin
    ack_d   = accept;
    rdata_d = accept ? rd_sel : '0;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_ack_o  = ack_q & wb_cycle_i;
  assign wb_data_o = wb_ack_o ? rdata_q : '0;

endmodule

// File: tb/tb_wb_reg_bank.sv
module tb_wb_reg_bank;
  import wb_reg_bank_pkg::*;

  localparam int RC = 2;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int FW = RC * DW;
  localparam logic [FW-1:0] RST_V   = 16'h0002;
  localparam logic [FW-1:0] PULSE_M = 16'h0080;
  localparam logic [FW-1:0] RO_M    = 16'hF000;
  localparam logic [FW-1:0] W1C_M   = 16'h0C00;

  logic          clock_i;
  logic          reset_n_i;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_data_i;
  logic [DW-1:0] wb_data_o;
  logic          wb_we_i;
  logic          wb_cycle_i;
  logic          wb_strobe_i;
  logic          wb_stall_o;
  logic          wb_ack_o;
  logic [FW-1:0] hw_status_i;
  logic [FW-1:0] hw_event_i;
  logic [FW-1:0] reg_o;

  wb_reg_bank #(
    .REG_COUNT   (RC),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .RESET_VALUE (RST_V),
    .RO_MASK     (RO_M),
    .W1C_MASK    (W1C_M),
    .PULSE_MASK  (PULSE_M)
  ) dut (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .wb_data_o   (wb_data_o),
    .wb_we_i     (wb_we_i),
    .wb_cycle_i  (wb_cycle_i),
    .wb_strobe_i (wb_strobe_i),
    .wb_stall_o  (wb_stall_o),
    .wb_ack_o    (wb_ack_o),
    .hw_status_i (hw_status_i),
    .hw_event_i  (hw_event_i),
    .reg_o       (reg_o)
  );

  // ---------------- clock / reset ----------------
  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];      // expected read data, one per accepted request
  logic [DW-1:0] m_store [RC];  // level bits (RW/W1C)
  logic [DW-1:0] m_pulse [RC];  // pulse bits visible this cycle
  logic          m_ack_pend;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic reg_bit_mode_t mode_of(input int r, input int b);
    int f;
    f = r * DW + b;
    return bit_mode(RO_M[f], W1C_M[f], PULSE_M[f]);
  endfunction

  function automatic logic [FW-1:0] model_image();
    logic [FW-1:0] img;
    img = '0;
    for (int r = 0; r < RC; r++)
      for (int b = 0; b < DW; b++)
        case (mode_of(r, b))
          REG_BIT_RO:    img[r*DW+b] = hw_status_i[r*DW+b];
          REG_BIT_PULSE: img[r*DW+b] = m_pulse[r][b];
          default:       img[r*DW+b] = m_store[r][b];
        endcase
    return img;
  endfunction

  function automatic logic [DW-1:0] model_read(input int a);
    logic [DW-1:0] v;
    v = '0;
    if (a < RC)
      for (int b = 0; b < DW; b++)
        case (mode_of(a, b))
          REG_BIT_RO:    v[b] = hw_status_i[a*DW+b];
          REG_BIT_PULSE: v[b] = 1'b0;
          default:       v[b] = m_store[a][b];
        endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < RC; r++) begin
      m_store[r] = RST_V[r*DW +: DW];
      m_pulse[r] = '0;
    end
    m_ack_pend = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model across one clock edge using the inputs now driven.
  task automatic model_step();
    logic acc;
    logic hit;
    int   a;
    acc = wb_cycle_i & wb_strobe_i;
    a   = int'(wb_addr_i);
    if (acc) exp_q.push_back(model_read(a));
    m_ack_pend = acc;
    for (int r = 0; r < RC; r++)
      for (int b = 0; b < DW; b++) begin
        hit = acc && wb_we_i && (a == r);
        case (mode_of(r, b))
          REG_BIT_RW: if (hit) m_store[r][b] = wb_data_i[b];
          REG_BIT_W1C: begin
            if (hit && wb_data_i[b]) m_store[r][b] = 1'b0;
            if (hw_event_i[r*DW+b])  m_store[r][b] = 1'b1;
          end
          REG_BIT_PULSE: m_pulse[r][b] = hit && wb_data_i[b];
          default: ;
        endcase
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wb_cycle_i  = cyc;
    wb_strobe_i = stb;
    wb_we_i     = we;
    wb_addr_i   = addr;
    wb_data_i   = data;
  endtask

  // Called at posedge+1: check this cycle's outputs, step model, clock.
  task automatic tick();
    logic [DW-1:0] d;
    logic [DW-1:0] exp_data;
    #2;
    exp_data = '0;
    if (m_ack_pend) begin
      d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (wb_cycle_i) exp_data = d;
    end
    check_eq("ack",   wb_ack_o,  m_ack_pend & wb_cycle_i);
    check_eq("rdata", wb_data_o, exp_data);
    check_eq("reg_o", reg_o,     model_image());
    check_eq("stall", wb_stall_o, 0);
    model_step();
    @(posedge clock_i);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks;
    reset_n_i   = 1'b0;
    hw_status_i = '0;
    hw_event_i  = '0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clock_i);
    #3;
    check_eq("rst_ack",   wb_ack_o,  0);
    check_eq("rst_rdata", wb_data_o, 0);
    check_eq("rst_reg_o", reg_o,     16'h0002);
    @(posedge clock_i);
    #1;
    reset_n_i = 1'b1;

    // 1. read reg0 after reset
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0); #1;
    check_eq("t1_ack",   wb_ack_o,  1);
    check_eq("t1_rdata", wb_data_o, 8'h02);
    tick();

    // 2. RW + pulse bit
    drive(1, 1, 1, 0, 8'h81); tick();
    drive(1, 0, 0, 0, 0); #1;
    check_eq("t2_pulse_hi", reg_o[7:0], 8'h81);
    tick(); #1;
    check_eq("t2_pulse_lo", reg_o[7:0], 8'h01);
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0); #1;
    check_eq("t2_rdata", wb_data_o, 8'h01);
    tick();

    // 3. RO bits from status, RW low bits, W1C bits stay 0
    hw_status_i[15:8] = 8'hA0;
    drive(1, 1, 1, 1, 8'hFF); tick();
    drive(1, 1, 0, 1, 0);     tick();
    drive(1, 0, 0, 0, 0); #1;
    check_eq("t3_rdata", wb_data_o, 8'hA3);
    tick();

    // 4. W1C set / clear race
    hw_event_i[10] = 1'b1; tick();
    hw_event_i = '0; #1;
    check_eq("t4_set", reg_o[10], 1);
    hw_event_i[10] = 1'b1;
    drive(1, 1, 1, 1, 8'h04); tick();
    hw_event_i = '0;
    drive(1, 0, 0, 0, 0); #1;
    check_eq("t4_race", reg_o[10], 1);
    drive(1, 1, 1, 1, 8'h04); tick();
    drive(1, 0, 0, 0, 0); #1;
    check_eq("t4_clear", reg_o[10], 0);
    tick();

    // 5. back-to-back accepts with out-of-range index
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0)      drive(1, 1, 0, 0, 0);
      else if (k == 1) drive(1, 1, 1, 2, 8'hFF);
      else if (k == 2) drive(1, 1, 0, 0, 0);
      else             drive(1, 1, 0, 2, 0);
      #1;
      if (k > 0) acks += int'(wb_ack_o);
      tick();
    end
    drive(1, 0, 0, 0, 0); #1;
    acks += int'(wb_ack_o);
    check_eq("t5_acks",  acks,      4);
    check_eq("t5_oor_rd", wb_data_o, 8'h00);
    tick();

    // 6a. cycle abort: ack dropped, write kept
    drive(1, 1, 1, 0, 8'h3C); tick();
    drive(0, 0, 0, 0, 0); #1;
    check_eq("t6_abort_ack", wb_ack_o,   0);
    check_eq("t6_abort_wr",  reg_o[7:0], 8'h3C);
    tick();

    // 6b. reset while ack is high
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0); #1;
    check_eq("t6_ack_pre", wb_ack_o, 1);
    reset_n_i = 1'b0; #1;
    check_eq("t6_rst_ack",  wb_ack_o,   0);
    check_eq("t6_rst_data", wb_data_o,  0);
    check_eq("t6_rst_reg0", reg_o[7:0], 8'h02);
    model_reset();
    drive(1, 1, 1, 0, 8'h55);
    repeat (2) @(posedge clock_i);
    #1;
    reset_n_i = 1'b1;
    drive(1, 0, 0, 0, 0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) != 0), 1'(($urandom_range(0, 3) != 0)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
            DW'($urandom_range(0, 255)));
      hw_event_i = FW'($urandom) & FW'($urandom) & FW'($urandom);
      if ($urandom_range(0, 7) == 0) hw_status_i = FW'($urandom);
      tick();
    end
    hw_event_i = '0;
    drive(1, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
